cmd_uart_wrapper: RTL
=====================

// Module: cmd_uart_wrapper
// PURPOSE
//  Copter-side end of the host command link. Receives 3-byte frames over a UART line: cmd, data[15:8], data[7:0].
//  Presents each frame as cmd/data with a cmd_rdy flag for the flight-control command decoder.
//  Serialises one response byte per request (e.g. 0xA5 ack) back to the host on TX.
// PARAMETERS
//  BAUD_DIV      2604    clk cycles per UART bit (50 MHz / 19200 baud)
//  TIMEOUT_CLKS  1000000 max clk cycles between bytes of one frame (used only with BYTE_TIMEOUT_EN)
// PORTS
//  clk          in   1   system clock, single clock domain
//  rst          in   1   synchronous, active-high reset
//  RX           in   1   serial in from host, idle high, asynchronous
//  TX           out  1   serial out to host, idle high
//  cmd          out  8   opcode of last complete frame
//  data         out  16  payload of last complete frame ({byte2,byte3})
//  cmd_rdy      out  1   complete frame valid; held until cleared
//  clr_cmd_rdy  in   1   consumer acknowledge; clears cmd_rdy
//  resp         in   8   response byte to transmit
//  send_resp    in   1   1-cycle strobe: start transmitting resp
//  tx_busy      out  1   transmitter active; send_resp ignored while high
//  resp_sent    out  1   1-cycle pulse when stop bit of resp completes
// BEHAVIOUR
//  Reset: TX=1, cmd=0, data=0, cmd_rdy=0, tx_busy=0, resp_sent=0, all FSMs to IDLE, byte buffers 0.
//  UART format: 8N1, LSB first. RX passes through a 2-flop synchroniser (meta-hardened, idle value 1).
//  RX byte engine:
//   - falling edge on synced RX in IDLE -> START.
//   - START: wait BAUD_DIV/2. If RX is high there, treat as a glitch and return to IDLE.
//   - Otherwise sample 8 data bits each BAUD_DIV apart, then the stop bit.
//   - rx_rdy pulses 1 cycle at the stop-bit sample, whatever the stop-bit value (no framing error).
//  Frame FSM (states WAIT_CMD, WAIT_HI, WAIT_LO):
//   - WAIT_CMD + rx_rdy: latch cmd_buf, clear cmd_rdy -> WAIT_HI.
//   - WAIT_HI + rx_rdy: latch hi_buf -> WAIT_LO.
//   - WAIT_LO + rx_rdy: cmd<=cmd_buf, data<={hi_buf,byte}, cmd_rdy<=1 -> WAIT_CMD.
//   - cmd/data update only on frame completion; they are stable while cmd_rdy=1.
//   - cmd_rdy rises on the cycle after the 3rd rx_rdy.
//   - clr_cmd_rdy and a frame completion in the same cycle: set wins (cmd_rdy=1).
//   - A new frame's first byte clears cmd_rdy (stale command is dropped).
//  TX engine (states IDLE, TXING):
//   - send_resp in IDLE: load {1,resp,0} into a shift register and set tx_busy the next cycle.
//   - 10 bits shifted out, BAUD_DIV clks each.
//   - After the stop bit: resp_sent pulses 1 cycle, tx_busy falls on the same edge, TX=1.
//   - send_resp while tx_busy=1 is ignored (no queueing). Back-to-back send is allowed on the cycle tx_busy=0.
//  RX and TX run fully independently (full duplex).
//  rst mid-byte or mid-frame: all partial state discarded; the next falling edge begins a fresh byte in WAIT_CMD.
//  Baud counters are wide enough for BAUD_DIV-1 and reload on every bit boundary; no drift accumulation.
// CONFIGURATION
//  BYTE_TIMEOUT_EN defined:
//   - inter-byte counter runs in WAIT_HI/WAIT_LO and resets on each rx_rdy.
//   - Reaching TIMEOUT_CLKS returns the FSM to WAIT_CMD, discards buffered bytes, leaves cmd_rdy/cmd/data unchanged.
//  BYTE_TIMEOUT_EN undefined: no counter; the frame FSM waits indefinitely; TIMEOUT_CLKS unused.
// STRUCTURE
//  Package cmd_link_pkg: frame_state_t enum {WAIT_CMD,WAIT_HI,WAIT_LO}, uart_state_t enum, DEF_BAUD_DIV=2604,
//   RESP_ACK=8'hA5, opcode constants CMD_PTCH=8'h02..CMD_MOFF=8'h08.
//  Sub-module uart_rx_byte (synchroniser + bit sampler, outputs rx_byte[7:0], rx_rdy); frame FSM and TX inline.
// TESTING
//  1 Host sends 05,00,FF -> cmd_rdy=1 one clk after 3rd stop-bit sample, cmd=05, data=00FF; pulse clr_cmd_rdy -> cmd_rdy=0.
//  2 Frames 02,01,00 then 03,FF,80 without clear -> cmd_rdy drops at 2nd frame's 1st byte; final cmd=03, data=FF80.
//  3 send_resp with resp=A5 -> TX low for 2604 clks, bits 1,0,1,0,0,1,0,1 LSB first, stop high;
//    resp_sent pulses at 26040 clks; a 2nd send_resp at clk 100 is ignored.
//  4 rst asserted after byte1+4 bits of byte2, then frame 06,12,34 -> cmd=06, data=1234, no corruption.
//  5 (BYTE_TIMEOUT_EN) send 07,AA, idle 1.1M clks, send 08,00,00 -> cmd=08, data=0000; without macro -> cmd=07, data=AA08.
//  6 clr_cmd_rdy asserted on exact cycle of frame completion -> cmd_rdy=1 after the edge; 50-clk RX low glitch -> no rx_rdy.

Source files
------------

// File: rtl/cmd_link_pkg.sv
// Shared types and constants for the host command link (frame FSM, UART engines, opcodes).
package cmd_link_pkg;

  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} frame_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_state_t;
  typedef enum logic {TX_IDLE, TX_TXING} tx_state_t;

  localparam int DEF_BAUD_DIV     = 2604;
  localparam int DEF_TIMEOUT_CLKS = 1000000;

  localparam logic [7:0] RESP_ACK  = 8'hA5;

  localparam logic [7:0] CMD_PTCH  = 8'h02;
  localparam logic [7:0] CMD_ROLL  = 8'h03;
  localparam logic [7:0] CMD_YAW   = 8'h04;
  localparam logic [7:0] CMD_THRST = 8'h05;
  localparam logic [7:0] CMD_CAL   = 8'h06;
  localparam logic [7:0] CMD_MTRS  = 8'h07;
  localparam logic [7:0] CMD_MOFF  = 8'h08;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit glitch rejection, mid-bit sampling.
module uart_rx_byte
  import cmd_link_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_rdy
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  // sync[1] is the hardened line value, sync[2] its previous value for edge detection
  logic [2:0]       sync;
  logic             rx_s;
  logic             rx_prev;
  uart_state_t      state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [2:0]       bit_idx, next_bit_idx;
  logic [7:0]       shreg, next_shreg;

  assign rx_s    = sync[1];
  assign rx_prev = sync[2];
  assign rx_byte = shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 3'b111;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      sync    <= {sync[1:0], rx};
      state   <= next_state;
      cnt     <= next_cnt;
      bit_idx <= next_bit_idx;
      shreg   <= next_shreg;
    end
  end

  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    next_bit_idx = bit_idx;
    next_shreg   = shreg;
    rx_rdy       = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          next_state = RX_START;
          next_cnt   = '0;
        end
      end
      RX_START: begin
        // a line that is high again at mid start bit was only a glitch
        if (cnt == HALF_LAST) begin
          next_cnt     = '0;
          next_bit_idx = '0;
          next_state   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          next_cnt   = '0;
          next_shreg = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            next_state = RX_STOP;
          end else begin
            next_bit_idx = bit_idx + 1'b1;
          end
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          rx_rdy     = 1'b1;
          next_cnt   = '0;
          next_state = RX_IDLE;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: next_state = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/cmd_uart_wrapper.sv
// Copter-side command link: 3-byte frame assembly over UART RX plus a one-byte response TX.
// Optional BYTE_TIMEOUT_EN drops a partial frame when the host stalls between bytes.
module cmd_uart_wrapper
  import cmd_link_pkg::*;
#(
  parameter int BAUD_DIV     = DEF_BAUD_DIV,
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [7:0] rx_byte;
  logic       rx_rdy;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx      (RX),
    .rx_byte (rx_byte),
    .rx_rdy  (rx_rdy)
  );

  frame_state_t fstate, next_fstate;
  logic [7:0]   cmd_buf, next_cmd_buf;
  logic [7:0]   hi_buf, next_hi_buf;
  logic [7:0]   next_cmd;
  logic [15:0]  next_data;
  logic         next_cmd_rdy;
`ifdef BYTE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TO_W-1:0] to_cnt, next_to_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fstate  <= WAIT_CMD;
      cmd_buf <= '0;
      hi_buf  <= '0;
      cmd     <= '0;
      data    <= '0;
      cmd_rdy <= 1'b0;
`ifdef BYTE_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      fstate  <= next_fstate;
      cmd_buf <= next_cmd_buf;
      hi_buf  <= next_hi_buf;
      cmd     <= next_cmd;
      data    <= next_data;
      cmd_rdy <= next_cmd_rdy;
`ifdef BYTE_TIMEOUT_EN
      to_cnt  <= next_to_cnt;
`endif
    end
  end

  // clear is evaluated first so a same-cycle frame completion overrides it
  always_comb begin
    next_fstate  = fstate;
    next_cmd_buf = cmd_buf;
    next_hi_buf  = hi_buf;
    next_cmd     = cmd;
    next_data    = data;
    next_cmd_rdy = cmd_rdy;
    if (clr_cmd_rdy) next_cmd_rdy = 1'b0;
    case (fstate)
      WAIT_CMD: begin
        if (rx_rdy) begin
          next_cmd_buf = rx_byte;
          next_cmd_rdy = 1'b0;
          next_fstate  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rx_rdy) begin
          next_hi_buf = rx_byte;
          next_fstate = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          next_cmd     = cmd_buf;
          next_data    = {hi_buf, rx_byte};
          next_cmd_rdy = 1'b1;
          next_fstate  = WAIT_CMD;
        end
      end
      default: next_fstate = WAIT_CMD;
    endcase
`ifdef BYTE_TIMEOUT_EN
    next_to_cnt = '0;
    if ((fstate != WAIT_CMD) && !rx_rdy) begin
      if (to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
        next_fstate  = WAIT_CMD;
        next_cmd_buf = '0;
        next_hi_buf  = '0;
      end else begin
        next_to_cnt = to_cnt + 1'b1;
      end
    end
`endif
  end

  tx_state_t        tx_state, next_tx_state;
  logic [CNT_W-1:0] tx_cnt, next_tx_cnt;
  logic [3:0]       tx_bit, next_tx_bit;
  logic [8:0]       tx_shift, next_tx_shift;
  logic             tx_line, next_tx_line;
  logic             next_resp_sent;

  assign TX      = tx_line;
  assign tx_busy = (tx_state == TX_TXING);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_line   <= 1'b1;
      resp_sent <= 1'b0;
    end else begin
      tx_state  <= next_tx_state;
      tx_cnt    <= next_tx_cnt;
      tx_bit    <= next_tx_bit;
      tx_shift  <= next_tx_shift;
      tx_line   <= next_tx_line;
      resp_sent <= next_resp_sent;
    end
  end

  // start bit goes straight onto the line; tx_shift holds data bits then the stop bit
  always_comb begin
    next_tx_state  = tx_state;
    next_tx_cnt    = tx_cnt;
    next_tx_bit    = tx_bit;
    next_tx_shift  = tx_shift;
    next_tx_line   = tx_line;
    next_resp_sent = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (send_resp) begin
          next_tx_state = TX_TXING;
          next_tx_line  = 1'b0;
          next_tx_shift = {1'b1, resp};
          next_tx_cnt   = '0;
          next_tx_bit   = '0;
        end
      end
      TX_TXING: begin
        if (tx_cnt == BIT_LAST) begin
          next_tx_cnt = '0;
          if (tx_bit == 4'd9) begin
            next_tx_state  = TX_IDLE;
            next_tx_line   = 1'b1;
            next_resp_sent = 1'b1;
          end else begin
            next_tx_line  = tx_shift[0];
            next_tx_shift = {1'b1, tx_shift[8:1]};
            next_tx_bit   = tx_bit + 1'b1;
          end
        end else begin
          next_tx_cnt = tx_cnt + 1'b1;
        end
      end
      default: next_tx_state = TX_IDLE;
    endcase
  end

endmodule
